// File: rtl/rom_dl_sequencer.sv
// rtl/rom_dl_sequencer.sv - ROM download sequencer: forwards HPS bytes to the core and gates core reset
//
// Purpose:
//   Watches the HPS download window, forwards in-range bytes as ROM writes,
//   counts and checksums them, and decides at the end of the window whether
//   the image is valid. A valid image releases the core after a hold period.
//   An invalid image keeps the core in reset until the next download.
//
// Ports:
//   clk_sys        - single clock, rising edge
//   reset_n        - synchronous active-low reset
//   ioctl_download - HPS download window active
//   ioctl_wr       - single-cycle byte write strobe
//   ioctl_addr     - byte address of the write (25 bits)
//   ioctl_dout     - write data byte
//   user_reset     - menu/button reset request (level)
//   dn_addr        - ROM write address to the core
//   dn_data        - ROM write data
//   dn_wr          - ROM write strobe, one cycle after the accepted ioctl_wr
//   core_reset     - active-high core reset, low only while running
//   dl_done        - last load valid
//   dl_err         - last load invalid
//   checksum       - mod-2^16 sum of bytes accepted in the last load

module rom_dl_sequencer #(
  parameter int EXPECTED_LEN = 20512,
  parameter int HOLD_CYCLES  = 256
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        user_reset,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic        core_reset,
  output logic        dl_done,
  output logic        dl_err,
  output logic [15:0] checksum
);

  localparam logic [24:0] ADDR_LIMIT = 25'(EXPECTED_LEN);
  localparam logic [16:0] CNT_LIMIT  = 17'(EXPECTED_LEN);
  localparam logic [15:0] HOLD_INIT  = 16'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    HOLD = 3'd2,
    RUN  = 3'd3,
    ERR  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        dl_prev_q, dl_prev_d;
  logic [16:0] byte_cnt_q, byte_cnt_d;
  logic        ovf_q, ovf_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic        dn_wr_q, dn_wr_d;
  logic [15:0] dn_addr_q, dn_addr_d;
  logic [7:0]  dn_data_q, dn_data_d;
  logic        core_reset_q, core_reset_d;
  logic        dl_done_q, dl_done_d;
  logic        dl_err_q, dl_err_d;
  logic [15:0] checksum_q, checksum_d;

  logic dl_rise, dl_fall, in_range, accept, drop;

  always_comb begin
    state_d    = state_q;
    dl_prev_d  = ioctl_download;
    byte_cnt_d = byte_cnt_q;
    ovf_d      = ovf_q;
    hold_cnt_d = hold_cnt_q;
    dn_wr_d    = 1'b0;
    dn_addr_d  = dn_addr_q;
    dn_data_d  = dn_data_q;
    dl_done_d  = dl_done_q;
    dl_err_d   = dl_err_q;
    checksum_d = checksum_q;

    dl_rise  = ioctl_download & ~dl_prev_q;
    dl_fall  = ~ioctl_download & dl_prev_q;
    in_range = (ioctl_addr < ADDR_LIMIT);
    accept   = (state_q == LOAD) & ioctl_wr & in_range;
    drop     = (state_q == LOAD) & ioctl_wr & ~in_range;

    if (dl_rise) begin
      // A new window wins over everything, including a running core.
      state_d    = LOAD;
      byte_cnt_d = '0;
      checksum_d = '0;
      ovf_d      = 1'b0;
      dl_done_d  = 1'b0;
      dl_err_d   = 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (accept) begin
            dn_wr_d    = 1'b1;
            dn_addr_d  = ioctl_addr[15:0];
            dn_data_d  = ioctl_dout;
            checksum_d = checksum_q + {8'h00, ioctl_dout};
            // Saturate so repeated writes can never wrap back onto a valid count.
            if (byte_cnt_q != '1) begin
              byte_cnt_d = byte_cnt_q + 17'd1;
            end
          end
          if (drop) begin
            ovf_d = 1'b1;
          end
          // Judge with the _d values so a write landing on the falling edge counts.
          if (dl_fall) begin
            if (byte_cnt_d == CNT_LIMIT && !ovf_d) begin
              state_d    = HOLD;
              hold_cnt_d = HOLD_INIT;
              dl_done_d  = 1'b1;
            end else begin
              state_d  = ERR;
              dl_err_d = 1'b1;
            end
          end
        end
        HOLD: begin
          if (user_reset) begin
            hold_cnt_d = HOLD_INIT;
          end else if (hold_cnt_q == 16'd0) begin
            state_d = RUN;
          end else begin
            hold_cnt_d = hold_cnt_q - 16'd1;
          end
        end
        RUN: begin
          if (user_reset) begin
            state_d    = HOLD;
            hold_cnt_d = HOLD_INIT;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    core_reset_d = (state_d != RUN);
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      dl_prev_q    <= 1'b0;
      byte_cnt_q   <= '0;
      ovf_q        <= 1'b0;
      hold_cnt_q   <= '0;
      dn_wr_q      <= 1'b0;
      dn_addr_q    <= '0;
      dn_data_q    <= '0;
      core_reset_q <= 1'b1;
      dl_done_q    <= 1'b0;
      dl_err_q     <= 1'b0;
      checksum_q   <= '0;
    end else begin
      state_q      <= state_d;
      dl_prev_q    <= dl_prev_d;
      byte_cnt_q   <= byte_cnt_d;
      ovf_q        <= ovf_d;
      hold_cnt_q   <= hold_cnt_d;
      dn_wr_q      <= dn_wr_d;
      dn_addr_q    <= dn_addr_d;
      dn_data_q    <= dn_data_d;
      core_reset_q <= core_reset_d;
      dl_done_q    <= dl_done_d;
      dl_err_q     <= dl_err_d;
      checksum_q   <= checksum_d;
    end
  end

  assign dn_addr    = dn_addr_q;
  assign dn_data    = dn_data_q;
  assign dn_wr      = dn_wr_q;
  assign core_reset = core_reset_q;
  assign dl_done    = dl_done_q;
  assign dl_err     = dl_err_q;
  assign checksum   = checksum_q;

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// tb/tb_rom_dl_sequencer.sv - self-checking bench for rom_dl_sequencer

module tb_rom_dl_sequencer;

  localparam int EXP_LEN  = 20512;
  localparam int HOLD_LEN = 256;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        user_reset;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic        core_reset;
  logic        dl_done;
  logic        dl_err;
  logic [15:0] checksum;

  int n_checks = 0;
  int n_errors = 0;

  rom_dl_sequencer #(
    .EXPECTED_LEN(EXP_LEN),
    .HOLD_CYCLES (HOLD_LEN)
  ) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .user_reset    (user_reset),
    .dn_addr       (dn_addr),
    .dn_data       (dn_data),
    .dn_wr         (dn_wr),
    .core_reset    (core_reset),
    .dl_done       (dl_done),
    .dl_err        (dl_err),
    .checksum      (checksum)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic cycle();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b1;
    ioctl_addr     = 25'(1234);
    ioctl_dout     = 8'h5A;
    user_reset     = 1'b1;
    cycle();
    cycle();
    n_checks++; if (core_reset !== 1'b1) begin n_errors++; $display("FAIL reset_core_reset: got %b expected 1", core_reset); end
    n_checks++; if (dn_wr !== 1'b0) begin n_errors++; $display("FAIL reset_dn_wr: got %b expected 0", dn_wr); end
    n_checks++; if (dn_addr !== 16'h0) begin n_errors++; $display("FAIL reset_dn_addr: got %h expected 0", dn_addr); end
    n_checks++; if (dn_data !== 8'h0) begin n_errors++; $display("FAIL reset_dn_data: got %h expected 0", dn_data); end
    n_checks++; if (dl_done !== 1'b0 || dl_err !== 1'b0) begin n_errors++; $display("FAIL reset_flags: got done=%b err=%b expected 0/0", dl_done, dl_err); end
    n_checks++; if (checksum !== 16'h0) begin n_errors++; $display("FAIL reset_checksum: got %h expected 0", checksum); end
    reset_n    = 1'b1;
    ioctl_wr   = 1'b0;
    user_reset = 1'b0;
    cycle();
  endtask

  // Strobes and user_reset outside a download window must do nothing from IDLE.
  task automatic test_idle_ignore();
    int bad = 0;
    for (int k = 0; k < 40; k++) begin
      ioctl_wr   = 1'($urandom_range(0, 1));
      ioctl_addr = 25'($urandom_range(0, 100));
      ioctl_dout = 8'($urandom);
      user_reset = 1'($urandom_range(0, 1));
      cycle();
      if (dn_wr !== 1'b0 || core_reset !== 1'b1 || dl_done !== 1'b0) bad++;
    end
    ioctl_wr   = 1'b0;
    user_reset = 1'b0;
    cycle();
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL idle_ignore: got %0d bad cycles expected 0", bad); end
  endtask

  // Full download window. Final write always coincides with the window fall.
  // Model: only addresses below EXP_LEN are forwarded; valid iff exactly EXP_LEN
  // bytes were accepted and nothing was dropped.
  task automatic do_load(input string name, input int nbytes, input bit ones, input bit add_ovf);
    int          bad = 0;
    int          first_bad = -1;
    int          pulses_exp = 0;
    logic [15:0] sum = 16'h0;
    logic [7:0]  d;
    bit          expect_ok;
    expect_ok = (nbytes == EXP_LEN) && !add_ovf;

    ioctl_download = 1'b1;
    ioctl_wr       = 1'b0;
    cycle();
    n_checks++; if (dl_done !== 1'b0 || dl_err !== 1'b0) begin n_errors++; $display("FAIL %s_start_flags: got done=%b err=%b expected 0/0", name, dl_done, dl_err); end
    n_checks++; if (checksum !== 16'h0) begin n_errors++; $display("FAIL %s_start_checksum: got %h expected 0", name, checksum); end
    n_checks++; if (core_reset !== 1'b1) begin n_errors++; $display("FAIL %s_start_core_reset: got %b expected 1", name, core_reset); end

    for (int i = 0; i < nbytes; i++) begin
      if (add_ovf && i == 100) begin
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'h6000;
        ioctl_dout = 8'hA5;
        cycle();
        if (dn_wr !== 1'b0) begin bad++; if (first_bad < 0) first_bad = 25'h6000; end
      end
      d = ones ? 8'h01 : 8'($urandom);
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = d;
      if (i == nbytes - 1) ioctl_download = 1'b0;
      cycle();
      sum = sum + {8'h00, d};
      pulses_exp++;
      if (dn_wr !== 1'b1 || dn_addr !== 16'(i) || dn_data !== d) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
      if (i != nbytes - 1 && $urandom_range(0, 63) == 0) begin
        ioctl_wr = 1'b0;
        cycle();
        if (dn_wr !== 1'b0) begin bad++; if (first_bad < 0) first_bad = i; end
      end
    end
    ioctl_wr   = 1'b0;
    ioctl_addr = '0;

    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL %s_dn_stream: got %0d bad of %0d writes (first at %0d) expected 0", name, bad, pulses_exp, first_bad); end
    n_checks++; if (checksum !== sum) begin n_errors++; $display("FAIL %s_checksum: got %h expected %h", name, checksum, sum); end
    n_checks++; if (dl_done !== expect_ok) begin n_errors++; $display("FAIL %s_dl_done: got %b expected %b", name, dl_done, expect_ok); end
    n_checks++; if (dl_err !== !expect_ok) begin n_errors++; $display("FAIL %s_dl_err: got %b expected %b", name, dl_err, !expect_ok); end
    n_checks++; if (core_reset !== 1'b1) begin n_errors++; $display("FAIL %s_end_core_reset: got %b expected 1", name, core_reset); end
  endtask

  // Called right after the edge that entered (or last reloaded) HOLD:
  // core_reset must stay high for HOLD_LEN-1 more edges and drop on edge HOLD_LEN.
  task automatic check_release(input string name);
    int bad = 0;
    int first_bad = -1;
    for (int k = 1; k <= HOLD_LEN; k++) begin
      cycle();
      if (core_reset !== (k < HOLD_LEN)) begin bad++; if (first_bad < 0) first_bad = k; end
    end
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL %s_release: got %0d wrong cycles (first at %0d) expected 0", name, bad, first_bad); end
    n_checks++; if (core_reset !== 1'b0 || dl_done !== 1'b1) begin n_errors++; $display("FAIL %s_run: got core_reset=%b done=%b expected 0/1", name, core_reset, dl_done); end
  endtask

  task automatic test_full_load();
    do_load("full_ones", EXP_LEN, 1'b1, 1'b0);
    n_checks++; if (checksum !== 16'h5020) begin n_errors++; $display("FAIL full_ones_sum_const: got %h expected 5020", checksum); end
    check_release("full_ones");
  endtask

  task automatic test_user_reset();
    user_reset = 1'b1;
    cycle();
    user_reset = 1'b0;
    n_checks++; if (core_reset !== 1'b1) begin n_errors++; $display("FAIL ureset_pulse_enter: got %b expected 1", core_reset); end
    check_release("ureset_pulse");
    user_reset = 1'b1;
    repeat (5) cycle();
    user_reset = 1'b0;
    check_release("ureset_held");
  endtask

  task automatic test_abort_in_hold();
    user_reset = 1'b1;
    cycle();
    user_reset = 1'b0;
    repeat (10) cycle();
    n_checks++; if (core_reset !== 1'b1 || dl_done !== 1'b1) begin n_errors++; $display("FAIL hold_before_abort: got core_reset=%b done=%b expected 1/1", core_reset, dl_done); end
    do_load("short", 20480, 1'b0, 1'b0);
  endtask

  task automatic test_err_sticky();
    int bad = 0;
    ioctl_download = 1'b0;
    for (int k = 0; k < 400; k++) begin
      user_reset = 1'($urandom_range(0, 1));
      ioctl_wr   = 1'($urandom_range(0, 1));
      ioctl_addr = 25'($urandom_range(0, 30000));
      ioctl_dout = 8'($urandom);
      cycle();
      if (core_reset !== 1'b1 || dl_err !== 1'b1 || dn_wr !== 1'b0 || dl_done !== 1'b0) bad++;
    end
    user_reset = 1'b0;
    ioctl_wr   = 1'b0;
    cycle();
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL err_sticky: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_overflow();
    do_load("overflow", EXP_LEN, 1'b0, 1'b1);
  endtask

  task automatic test_reset_during_load();
    ioctl_download = 1'b1;
    cycle();
    for (int i = 0; i < 5; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = 8'($urandom);
      cycle();
    end
    reset_n    = 1'b0;
    ioctl_addr = 25'(5);
    cycle();
    n_checks++; if (dn_wr !== 1'b0 || checksum !== 16'h0 || core_reset !== 1'b1 || dl_err !== 1'b0) begin n_errors++; $display("FAIL rst_load_state: got wr=%b sum=%h cr=%b err=%b expected 0/0000/1/0", dn_wr, checksum, core_reset, dl_err); end
    reset_n    = 1'b1;
    ioctl_addr = 25'(6);
    cycle();
    n_checks++; if (dn_wr !== 1'b0) begin n_errors++; $display("FAIL rst_load_after: got dn_wr=%b expected 0", dn_wr); end
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    cycle();
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_full_load();
    test_user_reset();
    test_abort_in_hold();
    test_err_sticky();
    test_overflow();
    test_reset_during_load();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
